// File: rtl/audio_pkg.sv
// Shared definitions for the audio beep controller.
//   state_t       : controller state (IDLE, PLAY)
//   PWM_W         : PWM counter / amplitude width
//   DEF_*         : default parameter values (25 MHz clock)
//   cnt_w()       : counter width needed to hold values 0..n-1 (minimum 1)
package audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int PWM_W         = 8;

    localparam int DEF_HALF_PER  = 12500;
    localparam int DEF_BEEP_CYC  = 2500000;
    localparam int DEF_AMP       = 192;
    localparam int DEF_DECAY_DIV = 9766;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_pwm.sv
// 8-bit PWM generator: free-running counter compared against a level.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears counter and output
//   level : high count out of 256 (0 gives constant low)
//   pwm   : registered PWM output, one cycle behind level
module audio_pwm
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] level,
    output logic             pwm
);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm     <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/audio_controller.sv
// Beep controller: a hit starts (or extends) a fixed-length burst of a
// square-wave tone, rendered as PWM on audioOut.
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   hit      : level-sensitive trigger; any high cycle starts/extends a burst
//   chSel    : channel select, tied 0
//   audioOut : registered PWM audio
//   audioEn  : amplifier enable, high while a burst plays
// Optional build macro AUDIO_DECAY_EN: amplitude decays by one step every
// DECAY_DIV cycles of a burst, saturating at 0.
//
// state | meaning
// IDLE  | silent, waiting for hit
// PLAY  | burst playing; tone running, burst counter counting down
module audio_controller
    import audio_pkg::*;
#(
    parameter int HALF_PER  = DEF_HALF_PER,
    parameter int BEEP_CYC  = DEF_BEEP_CYC,
    parameter int AMP       = DEF_AMP,
    parameter int DECAY_DIV = DEF_DECAY_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    output logic chSel,
    output logic audioOut,
    output logic audioEn
);

    localparam int BW = cnt_w(BEEP_CYC);
    localparam int TW = cnt_w(HALF_PER);

    localparam logic [BW-1:0]    BURST_LOAD = BW'(BEEP_CYC - 1);
    localparam logic [TW-1:0]    TONE_LAST  = TW'(HALF_PER - 1);
    localparam logic [PWM_W-1:0] AMP_LOAD   = PWM_W'(AMP);

    state_t           state;
    logic [BW-1:0]    burst_cnt;
    logic [TW-1:0]    tone_cnt;
    logic             phase;
    logic [PWM_W-1:0] amp;
    logic [PWM_W-1:0] level;

`ifdef AUDIO_DECAY_EN
    localparam int            DW         = cnt_w(DECAY_DIV);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_DIV - 1);
    logic [DW-1:0] decay_cnt;
`else
    logic unused_decay_div;
    assign unused_decay_div = (DECAY_DIV != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            tone_cnt  <= '0;
            phase     <= 1'b0;
            amp       <= '0;
`ifdef AUDIO_DECAY_EN
            decay_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state     <= PLAY;
                        burst_cnt <= BURST_LOAD;
                        tone_cnt  <= '0;
                        phase     <= 1'b1;
                        amp       <= AMP_LOAD;
`ifdef AUDIO_DECAY_EN
                        decay_cnt <= '0;
`endif
                    end
                end
                PLAY: begin
                    if (tone_cnt == TONE_LAST) begin
                        tone_cnt <= '0;
                        phase    <= ~phase;
                    end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                    end
`ifdef AUDIO_DECAY_EN
                    if (decay_cnt == DECAY_LAST) begin
                        decay_cnt <= '0;
                        if (amp != '0)
                            amp <= amp - 1'b1;
                    end else begin
                        decay_cnt <= decay_cnt + 1'b1;
                    end
`endif
                    // Retrigger takes priority over the end of burst, and its
                    // amplitude reload overrides any decay step on this edge.
                    if (hit) begin
                        burst_cnt <= BURST_LOAD;
                        amp       <= AMP_LOAD;
`ifdef AUDIO_DECAY_EN
                        decay_cnt <= '0;
`endif
                    end else if (burst_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        burst_cnt <= burst_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign level   = (state == PLAY && phase) ? amp : '0;
    assign audioEn = (state == PLAY);
    assign chSel   = 1'b0;

    audio_pwm u_pwm (
        .clk   (clk),
        .reset (reset),
        .level (level),
        .pwm   (audioOut)
    );

endmodule

// File: tb/tb_audio_controller.sv
module tb_audio_controller;

    localparam int HP = 4;
    localparam int BC = 40;
    localparam int AM = 128;
    localparam int DD = 8;

`ifdef AUDIO_DECAY_EN
    localparam int EXP_AMP8  = 127;
    localparam int EXP_AMP40 = 123;
`else
    localparam int EXP_AMP8  = 128;
    localparam int EXP_AMP40 = 128;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hit = 1'b0;
    logic chSel;
    logic audioOut;
    logic audioEn;

    always #5 clk = ~clk;

    audio_controller #(
        .HALF_PER  (HP),
        .BEEP_CYC  (BC),
        .AMP       (AM),
        .DECAY_DIV (DD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hit      (hit),
        .chSel    (chSel),
        .audioOut (audioOut),
        .audioEn  (audioEn)
    );

    typedef struct {
        logic en;
        logic out;
        logic ch;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Behavioural model: burst length as cycles remaining, tone phase from
    // cycles elapsed since the burst started, amplitude from cycles since load.
    int m_pwm = 0;
    int m_rem = 0;
    int m_age = 0;
    int m_since = 0;
    int m_amp = 0;
    bit m_play = 1'b0;

    function automatic int m_level();
        return (m_play && ((m_age / HP) % 2 == 0)) ? m_amp : 0;
    endfunction

    task automatic cycle(input logic h, input logic r);
        exp_t e;
        hit   = h;
        reset = r;
        @(posedge clk);
        if (r) begin
            m_play = 1'b0;
            m_pwm  = 0;
            m_amp  = 0;
            e.out  = 1'b0;
        end else begin
            e.out = (m_pwm < m_level());
            m_pwm = (m_pwm + 1) % 256;
            if (!m_play) begin
                if (h) begin
                    m_play  = 1'b1;
                    m_rem   = BC;
                    m_age   = 0;
                    m_since = 0;
                    m_amp   = AM;
                end
            end else begin
                m_age++;
                m_since++;
`ifdef AUDIO_DECAY_EN
                m_amp = (AM - m_since / DD > 0) ? AM - m_since / DD : 0;
`endif
                if (h) begin
                    m_rem   = BC;
                    m_since = 0;
                    m_amp   = AM;
                end else begin
                    m_rem--;
                    if (m_rem == 0)
                        m_play = 1'b0;
                end
            end
        end
        e.en = m_play;
        e.ch = 1'b0;
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0);
    endtask

    task automatic check_amp(input int exp_v, input string nm);
        checks++;
        if (int'(dut.amp) != exp_v) begin
            errors++;
            $display("FAIL %s: amplitude got %0d expected %0d", nm, dut.amp, exp_v);
        end
    endtask

    // Monitor: DUT presents a new output every cycle; compare at negedge.
    exp_t got_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            got_e = q.pop_front();
            checks += 3;
            if (audioEn !== got_e.en) begin
                errors++;
                $display("FAIL audioEn @%0t: got %0b expected %0b", $time, audioEn, got_e.en);
            end
            if (audioOut !== got_e.out) begin
                errors++;
                $display("FAIL audioOut @%0t: got %0b expected %0b", $time, audioOut, got_e.out);
            end
            if (chSel !== got_e.ch) begin
                errors++;
                $display("FAIL chSel @%0t: got %0b expected %0b", $time, chSel, got_e.ch);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then quiet idle.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        idle(100);

        // Single hit pulse, with amplitude probes after 8 and 40 PLAY cycles.
        cycle(1'b1, 1'b0);
        idle(8);
        check_amp(EXP_AMP8, "amp_after_8");
        idle(32);
        check_amp(EXP_AMP40, "amp_after_40");
        idle(10);

        // Retrigger 30 cycles into the burst.
        cycle(1'b1, 1'b0);
        idle(29);
        cycle(1'b1, 1'b0);
        idle(50);

        // Hit held for 10 cycles.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b0);
        idle(50);

        // Reset mid-burst, then hit together with reset.
        cycle(1'b1, 1'b0);
        idle(15);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        idle(10);

        // Retrigger on the edge where the burst counter is already 0.
        cycle(1'b1, 1'b0);
        idle(39);
        cycle(1'b1, 1'b0);
        idle(50);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: queue size got %0d expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_controller.md
AUDIO_CONTROLLER -- requirements
Module: audio_controller

Interface
REQ-001 SHALL have parameter HALF_PER, default 12500, tone half-period in clk cycles (1 kHz at 25 MHz); legal range >=1.
REQ-002 SHALL have parameter BEEP_CYC, default 2500000, burst length in clk cycles (100 ms at 25 MHz); legal range >=1.
REQ-003 SHALL have parameter AMP, default 192, 8-bit tone amplitude (PWM high count out of 256).
REQ-004 SHALL have parameter DECAY_DIV, default 9766, clk cycles per one-step amplitude decay; used only when AUDIO_DECAY_EN is defined.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset: synchronous, active-high.
REQ-007 hit  input  1  trigger request, sampled each clk edge; level-sensitive, any high cycle triggers.
REQ-008 chSel  output  1  channel select, constant 0 (rising-edge channel).
REQ-009 audioOut  output  1  registered PWM audio signal.
REQ-010 audioEn  output  1  audio amplifier enable, high only while a burst plays.

Function
REQ-011 SHALL implement two states: IDLE and PLAY; audioEn SHALL equal (state==PLAY) directly from the state register.
REQ-012 IDLE, hit=1 at edge k: state->PLAY, burst counter<=BEEP_CYC-1, tone counter<=0, phase<=1, amplitude<=AMP; audioEn high after edge k.
REQ-013 PLAY, hit=0: burst counter decrements by 1 per cycle; when 0 at an edge, state->IDLE; audioEn high for exactly BEEP_CYC cycles.
REQ-014 PLAY, hit=1 (retrigger): burst counter reloads BEEP_CYC-1, amplitude reloads AMP; tone counter and phase continue undisturbed.
REQ-015 Retrigger on the same edge the burst counter reaches 0 SHALL keep PLAY and reload (retrigger wins).
REQ-016 Tone: in PLAY, tone counter increments each cycle; at HALF_PER-1 it wraps to 0 and phase toggles; square-wave period 2*HALF_PER cycles.
REQ-017 Level SHALL be amplitude when state==PLAY and phase==1, else 0.
REQ-018 PWM counter SHALL be 8-bit, free-running, wrap 255->0, never reset except by reset.
REQ-019 audioOut SHALL be registered: audioOut <= (pwm_cnt < level); level 0 gives constant 0, one-cycle pipeline delay after level changes.
REQ-020 In IDLE, audioOut SHALL be 0 from the cycle after entering IDLE onward.
REQ-021 chSel SHALL be tied to 0 in all states including reset.

Reset
REQ-022 reset=1 at an edge SHALL force state IDLE, burst/tone/decay/PWM counters 0, phase 0, amplitude 0, audioOut 0, audioEn 0.
REQ-023 reset SHALL dominate hit on the same edge; reset mid-burst SHALL abort the burst immediately.

Configuration
REQ-024 Macro AUDIO_DECAY_EN defined: in PLAY, a decay counter counts DECAY_DIV cycles; each wrap decrements amplitude by 1, saturating at 0; reloaded with counter on trigger/retrigger.
REQ-025 AUDIO_DECAY_EN undefined: amplitude SHALL stay at AMP for the whole burst; decay counter absent.

Structure
REQ-026 Shared package audio_pkg SHALL hold the state enum (IDLE, PLAY), PWM width constant 8, and default parameter values.
REQ-027 The PWM comparator plus 8-bit counter SHALL be one sub-module, audio_pwm (inputs clk, reset, level[7:0]; output pwm).

Verification (bench params HALF_PER=4, BEEP_CYC=40, AMP=128, DECAY_DIV=8)
REQ-028 Reset then idle 100 cycles -> audioOut=0, audioEn=0, chSel=0 throughout.
REQ-029 One-cycle hit pulse -> audioEn high exactly 40 cycles; level alternates 128/0 every 4 cycles; audioOut duty 128/256 in phase-high windows.
REQ-030 Second hit 30 cycles into burst -> audioEn stays high 40 cycles after the second hit (70 total), no gap.
REQ-031 Hit held high 10 cycles from IDLE -> burst ends 40 cycles after the last high cycle.
REQ-032 reset asserted 15 cycles into burst -> next cycle audioEn=0, audioOut=0; hit with reset on same edge -> stays IDLE.
REQ-033 AUDIO_DECAY_EN build, AMP=128 -> amplitude 127 after 8 PLAY cycles, 123 after 40; non-decay build holds 128.
